// File: rtl/fila_de_instrucoes_core_if.sv
// fila_de_instrucoes_core_if: dispatch requests in, dispatched instruction and queue flags out
interface fila_de_instrucoes_core_if;
   logic        pop;
   logic        pop_r;
   logic        pop_i;
   logic [15:0] instrucao_despachada;
   logic        full;
   logic        empty;
   modport master (output pop, pop_r, pop_i, input instrucao_despachada, full, empty);
   modport slave (input pop, pop_r, pop_i, output instrucao_despachada, full, empty);
endinterface

// File: rtl/fila_de_instrucoes_core.sv
// fila_de_instrucoes_core: fetches a fixed ROM program into a circular queue and dispatches one entry per pop
module fila_de_instrucoes_core #(
   parameter int DEPTH    = 4,
   parameter int PROG_LEN = 16
) (
   input logic                      clk,
   input logic                      rst,
   fila_de_instrucoes_core_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   // pc is one bit wider than the ROM address so it can rest at PROG_LEN = 16
   logic [4:0]    pc;
   logic [15:0]   despachada;
   logic          fetch, pop;
   logic [15:0]   rom_word;
   // fetch/pop qualification from registered state; a full queue blocks fetch even when popping
   always_comb begin
      fetch    = (count < (AW+1)'(DEPTH)) && (pc < 5'(PROG_LEN));
      pop      = (bus.pop | bus.pop_r | bus.pop_i) && (count != '0);
      rom_word = {11'd0, pc} + 16'd1;
   end
   // queue storage is left uncleared by reset; count guards reads of stale entries
   always_ff @(posedge clk) begin
      if (fetch) mem[wr_ptr] <= rom_word;
   end
   // pointers, occupancy, fetch counter and registered dispatch output
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         despachada <= '0;
      end else begin
         if (fetch) begin
            wr_ptr <= wr_ptr + 1'b1;
            pc     <= pc + 5'd1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            despachada <= mem[rd_ptr];
         end
         count <= count + (AW+1)'(fetch) - (AW+1)'(pop);
      end
   end
   assign bus.instrucao_despachada = despachada;
   assign bus.full                 = (count == (AW+1)'(DEPTH));
   assign bus.empty                = (count == '0);
endmodule

// File: tb/tb_fila_de_instrucoes_core.sv
// tb_fila_de_instrucoes_core: directed vectors with hand-computed expectations for the instruction queue
module tb_fila_de_instrucoes_core;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   fila_de_instrucoes_core_if bus ();
   fila_de_instrucoes_core #(.DEPTH(4), .PROG_LEN(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic set_pops(input logic p, input logic pr, input logic pi);
      bus.pop   = p;
      bus.pop_r = pr;
      bus.pop_i = pi;
   endtask
   initial begin
      rst = 1'b1;
      set_pops(0, 0, 0);
      @(negedge clk);
      tick();
      check("reset_empty", 32'(bus.empty), 1);
      check("reset_full", 32'(bus.full), 0);
      check("reset_desp", 32'(bus.instrucao_despachada), 0);
      rst = 1'b0;
      tick();
      check("fill1_empty", 32'(bus.empty), 0);
      check("fill1_full", 32'(bus.full), 0);
      tick();
      tick();
      check("fill3_full", 32'(bus.full), 0);
      tick();
      check("fill4_full", 32'(bus.full), 1);
      tick();
      tick();
      check("hold_full", 32'(bus.full), 1);
      check("hold_desp", 32'(bus.instrucao_despachada), 0);
      set_pops(1, 0, 0);
      tick();
      check("pop_from_full_desp", 32'(bus.instrucao_despachada), 16'h0001);
      check("pop_from_full_full", 32'(bus.full), 0);
      set_pops(0, 0, 0);
      tick();
      check("refill_full", 32'(bus.full), 1);
      check("refill_desp_hold", 32'(bus.instrucao_despachada), 16'h0001);
      set_pops(1, 1, 1);
      tick();
      check("triple_pop_desp", 32'(bus.instrucao_despachada), 16'h0002);
      check("triple_pop_full", 32'(bus.full), 0);
      set_pops(0, 1, 0);
      tick();
      check("pop_r_desp", 32'(bus.instrucao_despachada), 16'h0003);
      set_pops(0, 0, 1);
      tick();
      check("pop_i_desp", 32'(bus.instrucao_despachada), 16'h0004);
      rst = 1'b1;
      set_pops(1, 0, 0);
      tick();
      check("rst_prio_desp", 32'(bus.instrucao_despachada), 0);
      check("rst_prio_empty", 32'(bus.empty), 1);
      rst = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         tick();
         check($sformatf("stream_desp_%0d", n), 32'(bus.instrucao_despachada), (n == 1) ? 0 : n - 1);
         check($sformatf("stream_empty_%0d", n), 32'(bus.empty), (n == 17) ? 1 : 0);
      end
      set_pops(1, 1, 1);
      for (int n = 0; n < 3; n++) begin
         tick();
         check("drained_desp", 32'(bus.instrucao_despachada), 16'h0010);
         check("drained_empty", 32'(bus.empty), 1);
         check("drained_full", 32'(bus.full), 0);
      end
      rst = 1'b1;
      set_pops(0, 0, 0);
      tick();
      rst = 1'b0;
      set_pops(1, 0, 0);
      for (int n = 0; n < 6; n++) tick();
      check("five_dispatched", 32'(bus.instrucao_despachada), 16'h0005);
      rst = 1'b1;
      tick();
      check("midrst_desp", 32'(bus.instrucao_despachada), 0);
      check("midrst_empty", 32'(bus.empty), 1);
      rst = 1'b0;
      tick();
      check("post_rst_ignored_pop", 32'(bus.instrucao_despachada), 0);
      tick();
      check("post_rst_first", 32'(bus.instrucao_despachada), 16'h0001);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
